// File: rtl/oric_audio_mixer.sv
// ---------------------------------------------------------------------------
// oric_audio_mixer
//
// Purpose:
//   PSG channel mixer for the Oric core with per-channel pan and a master
//   gain. A sample strobe latches NCH unsigned channel levels together with
//   their pan and the gain. The levels are then summed serially, one channel
//   per clock, into left/right accumulators. The sums are scaled by the gain
//   with saturation and presented as left-justified unsigned samples.
//
// Parameters:
//   NCH    number of input channels (1..16)
//   IN_W   width of each channel level
//   OUT_W  output sample width (must be >= ACC_W)
//
// Ports:
//   clk_sys    system clock
//   RESET      synchronous, active-high reset
//   ce_sample  start strobe, sampled on every clk_sys edge
//   ch_in      channel levels, channel k = ch_in[k*IN_W +: IN_W]
//   pan        per channel 2 bits: bit0 feeds left, bit1 feeds right
//   gain       master left-shift 0..3
//   audio_l    left sample, unsigned, left-justified
//   audio_r    right sample, unsigned, left-justified
//   out_valid  one-cycle pulse when audio_l/audio_r update
//   busy       accumulation in progress
//   overrun    sticky flag: a strobe arrived while busy
// ---------------------------------------------------------------------------
module oric_audio_mixer #(
   parameter int NCH   = 3,
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
) (
   input  logic                clk_sys,
   input  logic                RESET,
   input  logic                ce_sample,
   input  logic [NCH*IN_W-1:0] ch_in,
   input  logic [NCH*2-1:0]    pan,
   input  logic [1:0]          gain,
   output logic [OUT_W-1:0]    audio_l,
   output logic [OUT_W-1:0]    audio_r,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int ACC_W = IN_W + $clog2(NCH + 1);
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PAD_W = OUT_W - ACC_W;

   // The output must be wide enough to hold the full accumulator.
   generate
      if (OUT_W < ACC_W) begin : g_width_check
         $error("oric_audio_mixer: OUT_W must be >= ACC_W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCALE = 2'd2
   } state_t;

   state_t                state;
   logic [NCH*IN_W-1:0]   ch_shadow;
   logic [NCH*2-1:0]      pan_shadow;
   logic [1:0]            gain_shadow;
   logic [ACC_W-1:0]      acc_l;
   logic [ACC_W-1:0]      acc_r;
   logic [IDX_W-1:0]      idx;
   logic [ACC_W-1:0]      sat_l;
   logic [ACC_W-1:0]      sat_r;
   logic                  out_pending;

   logic [IN_W-1:0]       cur_ch;
   logic [1:0]            cur_pan;
   logic [ACC_W-1:0]      cur_ext;

   // Select the channel currently being accumulated from the shadow copies,
   // so that live input changes never reach an operation in flight.
   always_comb begin
      cur_ch  = ch_shadow[idx*IN_W +: IN_W];
      cur_pan = pan_shadow[idx*2 +: 2];
      cur_ext = {{(ACC_W-IN_W){1'b0}}, cur_ch};
   end

   // Shift by the gain in a wider word; any bit pushed beyond ACC_W means
   // the result no longer fits and clamps to all-ones.
   function automatic logic [ACC_W-1:0] scale_sat(input logic [ACC_W-1:0] a,
                                                  input logic [1:0]       g);
      logic [ACC_W+2:0] s;
      s = {3'b000, a} << g;
      if (|s[ACC_W+2:ACC_W])
         return '1;
      else
         return s[ACC_W-1:0];
   endfunction

   // Left-justify an accumulator-width value into the output width.
   function automatic logic [OUT_W-1:0] justify(input logic [ACC_W-1:0] v);
      logic [OUT_W-1:0] w;
      w = {{PAD_W{1'b0}}, v};
      return w << PAD_W;
   endfunction

   // Main sequencer. SCALE registers the saturated sums and returns to IDLE
   // straight away; the outputs are written from those registers one edge
   // later. This gives the NCH+2 clock strobe-to-output latency while leaving
   // the mixer IDLE (and able to accept a strobe) on the edge the outputs
   // update, so back-to-back strobes at the minimum period are not overruns.
   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         state       <= IDLE;
         ch_shadow   <= '0;
         pan_shadow  <= '0;
         gain_shadow <= '0;
         acc_l       <= '0;
         acc_r       <= '0;
         idx         <= '0;
         sat_l       <= '0;
         sat_r       <= '0;
         out_pending <= 1'b0;
         audio_l     <= '0;
         audio_r     <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         out_valid <= 1'b0;

         if (out_pending) begin
            audio_l     <= justify(sat_l);
            audio_r     <= justify(sat_r);
            out_valid   <= 1'b1;
            out_pending <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (ce_sample) begin
                  ch_shadow   <= ch_in;
                  pan_shadow  <= pan;
                  gain_shadow <= gain;
                  acc_l       <= '0;
                  acc_r       <= '0;
                  idx         <= '0;
                  busy        <= 1'b1;
                  state       <= ACCUM;
               end
            end

            ACCUM: begin
               if (ce_sample)
                  overrun <= 1'b1;
               if (cur_pan[0])
                  acc_l <= acc_l + cur_ext;
               if (cur_pan[1])
                  acc_r <= acc_r + cur_ext;
               if (idx == IDX_W'(NCH - 1))
                  state <= SCALE;
               else
                  idx <= idx + 1'b1;
            end

            SCALE: begin
               if (ce_sample)
                  overrun <= 1'b1;
               sat_l       <= scale_sat(acc_l, gain_shadow);
               sat_r       <= scale_sat(acc_r, gain_shadow);
               out_pending <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oric_audio_mixer.sv
// ---------------------------------------------------------------------------
// tb_oric_audio_mixer
//
// Purpose:
//   Self-checking bench for oric_audio_mixer with NCH=3, IN_W=8, OUT_W=16.
//   Expected samples come from a plain arithmetic model of the mixing rules:
//   sum the panned channel levels, shift by the gain, clamp to the 10-bit
//   accumulator range and left-justify by 6 bits.
// ---------------------------------------------------------------------------
module tb_oric_audio_mixer;

   logic        clk_sys;
   logic        RESET;
   logic        ce_sample;
   logic [23:0] ch_in;
   logic [5:0]  pan;
   logic [1:0]  gain;
   logic [15:0] audio_l;
   logic [15:0] audio_r;
   logic        out_valid;
   logic        busy;
   logic        overrun;

   int error_count;
   int check_count;
   bit exp_overrun;

   oric_audio_mixer #(
      .NCH   (3),
      .IN_W  (8),
      .OUT_W (16)
   ) dut (
      .clk_sys   (clk_sys),
      .RESET     (RESET),
      .ce_sample (ce_sample),
      .ch_in     (ch_in),
      .pan       (pan),
      .gain      (gain),
      .audio_l   (audio_l),
      .audio_r   (audio_r),
      .out_valid (out_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   // Free-running 100 MHz clock.
   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Reference model: side 0 = left, side 1 = right.
   function automatic logic [15:0] model(input logic [23:0] ch, input logic [5:0] pn,
                                         input logic [1:0] g, input int side);
      int sum;
      sum = 0;
      for (int k = 0; k < 3; k++)
         if (pn[2*k + side])
            sum += int'(ch[8*k +: 8]);
      sum = sum * (1 << g);
      if (sum > 1023)
         sum = 1023;
      return 16'(sum * 64);
   endfunction

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk_sys);
      RESET = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      RESET       = 1'b0;
      exp_overrun = 1'b0;
   endtask

   // Launch one strobe and follow it for 8 clocks, checking latency, pulse
   // width, busy, results, output holding and the sticky overrun flag.
   // With scramble set, the live inputs are randomised while the operation
   // is in flight; the result must still follow the strobed values.
   task automatic applyStimulus(input logic [23:0] ch, input logic [5:0] pn,
                                input logic [1:0] g, input bit scramble, input string tag);
      logic [15:0] el;
      logic [15:0] er;
      int          nvalid;
      int          vcyc;
      el = model(ch, pn, g, 0);
      er = model(ch, pn, g, 1);
      @(negedge clk_sys);
      ch_in     = ch;
      pan       = pn;
      gain      = g;
      ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      nvalid    = 0;
      vcyc      = -1;
      for (int c = 1; c <= 8; c++) begin
         if (scramble) begin
            ch_in = 24'($urandom);
            pan   = 6'($urandom);
            gain  = 2'($urandom);
         end
         @(posedge clk_sys);
         #1;
         if (c == 1) checkOutput({tag, "_busy_on"}, 32'(busy), 32'd1);
         if (c == 4) checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
         if (out_valid) begin
            nvalid++;
            if (vcyc < 0) begin
               vcyc = c;
               checkOutput({tag, "_L"}, 32'(audio_l), 32'(el));
               checkOutput({tag, "_R"}, 32'(audio_r), 32'(er));
            end
         end
      end
      checkOutput({tag, "_latency"}, 32'(vcyc), 32'd5);
      checkOutput({tag, "_pulses"}, 32'(nvalid), 32'd1);
      checkOutput({tag, "_hold_L"}, 32'(audio_l), 32'(el));
      checkOutput({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
   endtask

   initial begin
      logic [23:0] ch_a;
      logic [23:0] ch_b;
      logic [5:0]  pan_a;
      logic [5:0]  pan_b;
      logic [1:0]  gain_a;
      logic [1:0]  gain_b;
      int          nvalid;
      int          vcyc;

      error_count = 0;
      check_count = 0;
      exp_overrun = 1'b0;
      RESET       = 1'b0;
      ce_sample   = 1'b0;
      ch_in       = '0;
      pan         = '0;
      gain        = '0;

      doReset();
      checkOutput("reset_L", 32'(audio_l), 32'd0);
      checkOutput("reset_R", 32'(audio_r), 32'd0);
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);

      // Directed cases.
      applyStimulus(24'hFFFFFF, 6'b111111, 2'd0, 1'b0, "mono");
      applyStimulus(24'h402010, 6'b101101, 2'd0, 1'b0, "abc");
      applyStimulus(24'h000080, 6'b000011, 2'd1, 1'b0, "gain1");
      applyStimulus(24'hFFFFFF, 6'b111111, 2'd2, 1'b0, "sat");
      applyStimulus(24'h123456, 6'b011011, 2'd1, 1'b1, "scramble");
      applyStimulus(24'hFFFFFF, 6'b000000, 2'd3, 1'b0, "pan_off");

      // Randomised operations, half with inputs changing in flight.
      for (int n = 0; n < 24; n++)
         applyStimulus(24'($urandom), 6'($urandom), 2'($urandom), 1'($urandom), "rand");

      // Second strobe two clocks after the first: ignored, flags overrun.
      ch_a = 24'h302010; pan_a = 6'b111111; gain_a = 2'd0;
      ch_b = 24'hFFFFFF; pan_b = 6'b010101; gain_b = 2'd3;
      @(negedge clk_sys);
      ch_in = ch_a; pan = pan_a; gain = gain_a; ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      @(posedge clk_sys);
      #1;
      ch_in = ch_b; pan = pan_b; gain = gain_b; ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      nvalid = 0;
      for (int c = 3; c <= 10; c++) begin
         @(posedge clk_sys);
         #1;
         if (out_valid) begin
            nvalid++;
            checkOutput("ovr_L", 32'(audio_l), 32'(model(ch_a, pan_a, gain_a, 0)));
            checkOutput("ovr_R", 32'(audio_r), 32'(model(ch_a, pan_a, gain_a, 1)));
         end
      end
      checkOutput("ovr_pulses", 32'(nvalid), 32'd1);
      checkOutput("ovr_flag", 32'(overrun), 32'd1);
      exp_overrun = 1'b1;
      applyStimulus(24'h010203, 6'b111001, 2'd0, 1'b0, "ovr_sticky");

      doReset();
      checkOutput("ovr_cleared", 32'(overrun), 32'd0);

      // Strobe on the out_valid cycle is accepted and is not an overrun.
      ch_a = 24'h0A0B0C; pan_a = 6'b110110; gain_a = 2'd1;
      ch_b = 24'h776655; pan_b = 6'b011110; gain_b = 2'd2;
      @(negedge clk_sys);
      ch_in = ch_a; pan = pan_a; gain = gain_a; ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      repeat (5) @(posedge clk_sys);
      #1;
      checkOutput("b2b_first_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_first_L", 32'(audio_l), 32'(model(ch_a, pan_a, gain_a, 0)));
      ch_in = ch_b; pan = pan_b; gain = gain_b; ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      vcyc = -1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk_sys);
         #1;
         if (out_valid && vcyc < 0) begin
            vcyc = c;
            checkOutput("b2b_second_L", 32'(audio_l), 32'(model(ch_b, pan_b, gain_b, 0)));
            checkOutput("b2b_second_R", 32'(audio_r), 32'(model(ch_b, pan_b, gain_b, 1)));
         end
      end
      checkOutput("b2b_latency", 32'(vcyc), 32'd5);
      checkOutput("b2b_overrun", 32'(overrun), 32'd0);

      // RESET during ACCUM aborts the operation with no out_valid.
      @(negedge clk_sys);
      ch_in = 24'hFFFFFF; pan = 6'b111111; gain = 2'd0; ce_sample = 1'b1;
      @(posedge clk_sys);
      #1;
      ce_sample = 1'b0;
      @(posedge clk_sys);
      #1;
      RESET = 1'b1;
      @(posedge clk_sys);
      #1;
      RESET = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_L", 32'(audio_l), 32'd0);
      checkOutput("abort_R", 32'(audio_r), 32'd0);
      nvalid = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk_sys);
         #1;
         if (out_valid) nvalid++;
      end
      checkOutput("abort_no_valid", 32'(nvalid), 32'd0);
      applyStimulus(24'h405060, 6'b100111, 2'd1, 1'b0, "after_abort");

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
